// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the FSM state encoding, the stall/flush bundle and the load-use match rule.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         WAIT_W   = 16;

    // A load in E feeds a register that Decode reads; x0 never creates a dependency.
    function automatic logic load_use_hit(
        input logic       mem_rden,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       rs2_used
    );
        load_use_hit = mem_rden && (rd != REG_ZERO) &&
                       ((rd == rs1) || (rs2_used && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] value
);

    logic [W-1:0] value_r;

    // Count up on inc until the all-ones ceiling is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= {W{1'b0}};
        end else if (inc && (value_r != {W{1'b1}})) begin
            value_r <= value_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign value = value_r;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: LSU wait/timeout FSM, redirect and load-use resolution,
// per-stage stall/flush generation and saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       rs1_addr_D,
    input  logic [4:0]       rs2_addr_D,
    input  logic             rs2_used_D,
    input  logic [4:0]       rd_addr_E,
    input  logic             mem_rden_E,
    input  logic             pc_sel_E,
    input  logic             lsu_req_M,
    input  logic             lsu_ack_M,
    output logic             stall_F,
    output logic             stall_D,
    output logic             stall_E,
    output logic             stall_M,
    output logic             flush_D,
    output logic             flush_E,
    output logic             flush_W,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    state_e            state_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic              bus_err_r;
    logic              lsu_stall_s;
    logic              redirect_s;
    logic              load_use_s;
    ctrl_t             ctrl_s;

    // Classify the cycle: LSU hold outranks redirect, which outranks load-use
    always_comb begin
        lsu_stall_s = 1'b1;
        case (state_r)
            ST_RUN:      lsu_stall_s = lsu_req_M & ~lsu_ack_M;
            ST_MEM_WAIT: lsu_stall_s = ~lsu_ack_M;
            ST_ERR:      lsu_stall_s = 1'b1;
            default:     lsu_stall_s = 1'b1;
        endcase
        redirect_s = pc_sel_E & ~lsu_stall_s;
        load_use_s = ~lsu_stall_s & ~pc_sel_E &
                     load_use_hit(mem_rden_E, rd_addr_E, rs1_addr_D, rs2_addr_D, rs2_used_D);
    end

    // LSU wait sequencing; the ack cycle is a normal run cycle, an unknown state traps to ERR
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (lsu_req_M && !lsu_ack_M) begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = WAIT_ONE;
                end else begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                end
            end
            ST_MEM_WAIT: begin
                if (lsu_ack_M) begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                end else if (wait_cnt_r >= TIMEOUT_V) begin
                    state_nxt_s    = ST_ERR;
                    wait_cnt_nxt_s = wait_cnt_r;
                end else begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
                end
            end
            ST_ERR: begin
                state_nxt_s    = ST_ERR;
                wait_cnt_nxt_s = wait_cnt_r;
            end
            default: begin
                state_nxt_s    = ST_ERR;
                wait_cnt_nxt_s = wait_cnt_r;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= {WAIT_W{1'b0}};
            bus_err_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            wait_cnt_r <= wait_cnt_nxt_s;
            bus_err_r  <= bus_err_r | (state_nxt_s == ST_ERR);
        end
    end

    // Same-cycle stall/flush controls, forced quiet while reset is asserted
    always_comb begin
        ctrl_s = ctrl_t'(7'd0);
        if (i_rst_n) begin
            ctrl_s.stall_f = lsu_stall_s | load_use_s;
            ctrl_s.stall_d = lsu_stall_s | load_use_s;
            ctrl_s.stall_e = lsu_stall_s;
            ctrl_s.stall_m = lsu_stall_s;
            ctrl_s.flush_d = redirect_s;
            ctrl_s.flush_e = redirect_s | load_use_s;
            ctrl_s.flush_w = lsu_stall_s;
        end else begin
            ctrl_s = ctrl_t'(7'd0);
        end
    end

    assign stall_F = ctrl_s.stall_f;
    assign stall_D = ctrl_s.stall_d;
    assign stall_E = ctrl_s.stall_e;
    assign stall_M = ctrl_s.stall_m;
    assign flush_D = ctrl_s.flush_d;
    assign flush_E = ctrl_s.flush_e;
    assign flush_W = ctrl_s.flush_w;
    assign bus_err = bus_err_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (ctrl_s.stall_f),
        .value (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .inc   (redirect_s),
        .value (flush_cnt)
    );

endmodule
